// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: assembles each 32-bit instruction from four
// little-endian byte reads and hands pc/instruction to the IF/ID register.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [5:0]  stall,
   input  logic        branch_flag_in,
   input  logic [31:0] branch_target_in,
   input  logic        mem_ack_in,
   input  logic [7:0]  mem_byte_in,
   output logic        mem_req_out,
   output logic [31:0] mem_addr_out,
   output logic        stall_req_out,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      READY = 2'd2
   } state_t;

   state_t           state;
   logic [XLEN-1:0]  pc;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       byte0;
   logic [7:0]       byte1;
   logic [7:0]       byte2;

   // Only the IF/PC bit of the stall vector applies to this stage.
   logic unused_stall_c;
   assign unused_stall_c = |stall[5:1];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         cnt           <= '0;
         byte0         <= '0;
         byte1         <= '0;
         byte2         <= '0;
         mem_req_out   <= 1'b0;
         mem_addr_out  <= '0;
         stall_req_out <= 1'b1;
         if_pc         <= '0;
         if_inst       <= '0;
      end else if (branch_flag_in) begin
         // Redirect wins over everything; any partial fetch and same-cycle ack are dropped.
         state         <= FETCH;
         pc            <= branch_target_in;
         cnt           <= '0;
         mem_req_out   <= 1'b1;
         mem_addr_out  <= branch_target_in;
         stall_req_out <= 1'b1;
         if_pc         <= '0;
         if_inst       <= '0;
      end else begin
         case (state)
            IDLE: begin
               state         <= FETCH;
               cnt           <= '0;
               mem_req_out   <= 1'b1;
               mem_addr_out  <= pc;
               stall_req_out <= 1'b1;
            end
            FETCH: begin
               if (mem_ack_in) begin
                  if (cnt != CNT_W'(3)) begin
                     case (cnt)
                        2'd0:    byte0 <= mem_byte_in;
                        2'd1:    byte1 <= mem_byte_in;
                        default: byte2 <= mem_byte_in;
                     endcase
                     cnt          <= cnt + CNT_W'(1);
                     mem_addr_out <= pc + XLEN'(cnt) + XLEN'(1);
                  end else begin
                     state         <= READY;
                     mem_req_out   <= 1'b0;
                     stall_req_out <= 1'b0;
                     if_pc         <= pc;
                     if_inst       <= {mem_byte_in, byte2, byte1, byte0};
                  end
               end
            end
            READY: begin
               if (!stall[0]) begin
                  state         <= FETCH;
                  pc            <= pc + XLEN'(4);
                  cnt           <= '0;
                  mem_req_out   <= 1'b1;
                  mem_addr_out  <= pc + XLEN'(4);
                  stall_req_out <= 1'b1;
                  if_pc         <= '0;
                  if_inst       <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, straight-line fetch, stall hold,
// gapped acks, branch redirect, address wrap and asynchronous mid-fetch reset.
module tb_inst_fetch;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [5:0]  stall;
   logic        branch_flag_in;
   logic [31:0] branch_target_in;
   logic        mem_ack_in;
   logic [7:0]  mem_byte_in;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        stall_req_out;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int total = 0;
   int bad   = 0;

   inst_fetch dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .stall            (stall),
      .branch_flag_in   (branch_flag_in),
      .branch_target_in (branch_target_in),
      .mem_ack_in       (mem_ack_in),
      .mem_byte_in      (mem_byte_in),
      .mem_req_out      (mem_req_out),
      .mem_addr_out     (mem_addr_out),
      .stall_req_out    (stall_req_out),
      .if_pc            (if_pc),
      .if_inst          (if_inst)
   );

   always #5 clk_in = ~clk_in;

   // Byte-addressed instruction image; unlisted addresses return filler.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 8'h13;
         32'h0000_0001: return 8'h05;
         32'h0000_0002: return 8'h50;
         32'h0000_0003: return 8'h00;
         32'h0000_0004: return 8'h93;
         32'h0000_0005: return 8'h05;
         32'h0000_0006: return 8'ha0;
         32'h0000_0007: return 8'h00;
         32'h0000_0100: return 8'hb7;
         32'h0000_0101: return 8'h12;
         32'h0000_0102: return 8'h00;
         32'h0000_0103: return 8'h00;
         32'hFFFF_FFFC: return 8'hef;
         32'hFFFF_FFFD: return 8'h00;
         32'hFFFF_FFFE: return 8'h00;
         32'hFFFF_FFFF: return 8'h00;
         default:       return a[7:0] ^ 8'h5a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
   task automatic tick(input logic ack, input logic br, input logic [31:0] tgt, input logic st);
      @(negedge clk_in);
      mem_ack_in       = ack;
      mem_byte_in      = mem_byte(mem_addr_out);
      branch_flag_in   = br;
      branch_target_in = tgt;
      stall            = {5'b0, st};
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   32'(mem_req_out),   32'h0);
      chk({tag, "_addr"},  mem_addr_out,       32'h0);
      chk({tag, "_stall"}, 32'(stall_req_out), 32'h1);
      chk({tag, "_pc"},    if_pc,              32'h0);
      chk({tag, "_inst"},  if_inst,            32'h0);
   endtask

   initial begin
      rst_in           = 1'b0;
      stall            = '0;
      branch_flag_in   = 1'b0;
      branch_target_in = '0;
      mem_ack_in       = 1'b0;
      mem_byte_in      = '0;

      tick(1'b0, 1'b0, 32'h0, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk_reset_vals("reset");

      @(negedge clk_in);
      rst_in = 1'b1;

      // First fetch from RESET_PC, ack every cycle.
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk("idle_to_fetch_req", 32'(mem_req_out), 32'h1);
      chk("fetch0_addr", mem_addr_out, 32'h0);
      chk("fetch0_stall", 32'(stall_req_out), 32'h1);
      for (int i = 1; i < 4; i++) begin
         tick(1'b1, 1'b0, 32'h0, 1'b0);
         chk("fetch0_addr_seq", mem_addr_out, 32'(i));
         chk("fetch0_inst_zero", if_inst, 32'h0);
      end
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("ready0_inst", if_inst, 32'h0050_0513);
      chk("ready0_pc", if_pc, 32'h0);
      chk("ready0_stall", 32'(stall_req_out), 32'h0);
      chk("ready0_req", 32'(mem_req_out), 32'h0);

      // Hold READY under stall[0] for three cycles.
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1);
         chk("stall_hold_inst", if_inst, 32'h0050_0513);
         chk("stall_hold_req", 32'(mem_req_out), 32'h0);
         chk("stall_hold_stallreq", 32'(stall_req_out), 32'h0);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk("release_addr", mem_addr_out, 32'h4);
      chk("release_inst_bubble", if_inst, 32'h0);
      chk("release_pc_zero", if_pc, 32'h0);
      chk("release_stallreq", 32'(stall_req_out), 32'h1);

      // Acks on every other cycle: address holds while ack is low.
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b0);
         chk("gap_addr_hold", mem_addr_out, 32'(4 + i));
         chk("gap_stallreq", 32'(stall_req_out), 32'h1);
         tick(1'b1, 1'b0, 32'h0, 1'b0);
      end
      chk("gap_ready_inst", if_inst, 32'h00a0_0593);
      chk("gap_ready_pc", if_pc, 32'h4);
      chk("gap_ready_stallreq", 32'(stall_req_out), 32'h0);

      // Branch arrives with cnt = 2 and an ack in the same cycle.
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk("seq_addr8", mem_addr_out, 32'h8);
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("pre_branch_addr", mem_addr_out, 32'ha);
      tick(1'b1, 1'b1, 32'h100, 1'b0);
      chk("branch_addr", mem_addr_out, 32'h100);
      chk("branch_req", 32'(mem_req_out), 32'h1);
      chk("branch_inst_bubble", if_inst, 32'h0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("branch_ready_pc", if_pc, 32'h100);
      chk("branch_ready_inst", if_inst, 32'h0000_12b7);

      // Branch in READY while stalled still redirects; then wrap past 2^32.
      tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      chk("branch_stall_addr", mem_addr_out, 32'hFFFF_FFFC);
      chk("branch_stall_pc", if_pc, 32'h0);
      chk("branch_stall_stallreq", 32'(stall_req_out), 32'h1);
      for (int i = 1; i < 4; i++) begin
         tick(1'b1, 1'b0, 32'h0, 1'b0);
         chk("wrap_addr_seq", mem_addr_out, 32'hFFFF_FFFC + 32'(i));
      end
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("wrap_ready_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_ready_inst", if_inst, 32'h0000_00ef);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk("wrap_next_addr", mem_addr_out, 32'h0);

      // Asynchronous reset pulse between edges in the middle of a fetch.
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("pre_reset_addr", mem_addr_out, 32'h2);
      @(negedge clk_in);
      mem_ack_in = 1'b0;
      #1 rst_in = 1'b0;
      #1 chk_reset_vals("async_reset");
      #1 rst_in = 1'b1;
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk("restart_addr", mem_addr_out, 32'h0);
      chk("restart_req", 32'(mem_req_out), 32'h1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("restart_inst", if_inst, 32'h0050_0513);
      chk("restart_pc", if_pc, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
